// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (16x oversampled, optional even parity) feeding a small FWFT receive FIFO.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   i_rxd             serial input, idle high, asynchronous to clk
//   i_ctrl_rxen       receiver enable; low aborts any frame in progress
//   i_ctrl_baud       selects BAUD_DIV0..3 as clocks per oversample tick
//   i_lp_en, i_lp_div low-power override, tick period = i_lp_div+1 clocks
//   i_pop             one-cycle pop of the head entry
//   o_rx_data/ferr/perr  head entry, zero while empty
//   o_rx_empty        FIFO empty
//   o_rx_busy         frame reception in progress
//   o_rx_irq          pulse on each accepted push
//   o_rx_ovf          pulse when a completed frame is dropped on a full FIFO
module uart_rx_fifo #(
    parameter int BAUD_DIV0  = 4,
    parameter int BAUD_DIV1  = 8,
    parameter int BAUD_DIV2  = 16,
    parameter int BAUD_DIV3  = 32,
    parameter int PARITY_EN  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rxd,
    input  logic       i_ctrl_rxen,
    input  logic [1:0] i_ctrl_baud,
    input  logic       i_lp_en,
    input  logic [7:0] i_lp_div,
    input  logic       i_pop,
    output logic [7:0] o_rx_data,
    output logic       o_rx_ferr,
    output logic       o_rx_perr,
    output logic       o_rx_empty,
    output logic       o_rx_busy,
    output logic       o_rx_irq,
    output logic       o_rx_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t      r_state, w_next;
    logic        r_sync1, r_sync2, r_prev;
    logic [15:0] r_div, r_tcnt, w_div_sel;
    logic [3:0]  r_oc;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_ferr, r_perr, r_push;
    logic        w_start, w_tick, w_samp, w_end;
    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic        w_empty, w_full, w_rd, w_wr;
    // r_prev is the one-cycle-delayed synchronised line, used only for edge detection
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {r_sync1, r_sync2, r_prev} <= 3'b111;
        else        {r_sync1, r_sync2, r_prev} <= {i_rxd, r_sync1, r_sync2};
    always_comb begin
        w_div_sel = i_lp_en ? 16'(i_lp_div) + 16'd1 :
                    i_ctrl_baud == 2'd0 ? 16'(BAUD_DIV0) :
                    i_ctrl_baud == 2'd1 ? 16'(BAUD_DIV1) :
                    i_ctrl_baud == 2'd2 ? 16'(BAUD_DIV2) : 16'(BAUD_DIV3);
    end
    assign w_start = (r_state == IDLE) && i_ctrl_rxen && r_prev && !r_sync2;
    assign w_tick  = (r_state != IDLE) && (r_tcnt == r_div - 16'd1);
    assign w_samp  = w_tick && (r_oc == 4'd7);
    assign w_end   = w_tick && (r_oc == 4'd15);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (!i_ctrl_rxen) w_next = IDLE;
        else
            case (r_state)
                IDLE:    w_next = w_start ? START : IDLE;
                START:   w_next = (w_samp && r_sync2) ? IDLE : w_end ? DATA : START;
                DATA:    w_next = (w_end && r_bit == 3'd7) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
                PARITY:  w_next = w_end ? STOP : PARITY;
                STOP:    w_next = w_samp ? IDLE : STOP;
                default: w_next = IDLE;
            endcase
    end
    // The frame is pushed the clock after the stop-bit sample; the rest of the stop bit is not waited for.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_div   <= 16'd1;
            r_tcnt  <= '0;
            r_oc    <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_push  <= 1'b0;
        end else begin
            r_push <= i_ctrl_rxen && (r_state == STOP) && w_samp;
            if (w_start) begin
                r_div  <= w_div_sel;
                r_tcnt <= '0;
                r_oc   <= '0;
                r_bit  <= '0;
                r_perr <= 1'b0;
            end else if (r_state != IDLE) begin
                r_tcnt <= w_tick ? '0 : r_tcnt + 16'd1;
                if (w_tick) r_oc <= r_oc + 4'd1;
            end
            if (r_state == DATA && w_samp)   r_shift <= {r_sync2, r_shift[7:1]};
            if (r_state == DATA && w_end)    r_bit   <= r_bit + 3'd1;
            if (r_state == PARITY && w_samp) r_perr  <= r_sync2 ^ (^r_shift);
            if (r_state == STOP && w_samp)   r_ferr  <= ~r_sync2;
        end
    assign w_empty = r_wptr == r_rptr;
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd    = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is still accepted.
    assign w_wr    = r_push && (!w_full || w_rd);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= {r_perr, r_ferr, r_shift};
    assign {o_rx_perr, o_rx_ferr, o_rx_data} = w_empty ? 10'd0 : r_mem[r_rptr[AW-1:0]];
    assign o_rx_empty = w_empty;
    assign o_rx_busy  = r_state != IDLE;
    assign o_rx_irq   = w_wr;
    assign o_rx_ovf   = r_push && w_full && !w_rd;
endmodule
